// File: rtl/dffns_pipe.sv
// Falling-edge WIDTH x DEPTH delay line with async set-to-value, valid tracking, stall and flush.
// Optional DFFNS_PIPE_NOTIFIER_EN adds a notifier input that X-corrupts all stages on any toggle.

module dffns_pipe_stage #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clkn_i,
  input  logic             set_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
`ifdef DFFNS_PIPE_NOTIFIER_EN
  ,
  input  logic             notifier
`endif
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Bubbles advance the valid bit only; data stays put so a stalled word is never clobbered.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (en_i) begin
      vld_d = vld_i;
      if (vld_i) data_d = data_i;
    end
  end

`ifdef DFFNS_PIPE_NOTIFIER_EN
  logic notif_q;
  // notif_q tracks the last seen notifier level; a mismatch means the notifier itself woke us.
  always_ff @(negedge clkn_i or posedge set_i or posedge notifier or negedge notifier) begin
    if (set_i) begin
      vld_q   <= 1'b0;
      data_q  <= SET_VALUE;
      notif_q <= notifier;
    end else if (notifier !== notif_q) begin
      vld_q   <= 1'bx;
      data_q  <= {WIDTH{1'bx}};
      notif_q <= notifier;
    end else begin
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end
`else
  always_ff @(negedge clkn_i or posedge set_i) begin
    if (set_i) begin
      vld_q  <= 1'b0;
      data_q <= SET_VALUE;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end
`endif

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

module dffns_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
  input  logic                       CLKN,
  input  logic                       SET,
  input  logic                       EN,
  input  logic                       FLUSH,
  input  logic                       VLD_I,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic                       VLD_O,
  output logic [$clog2(DEPTH+1)-1:0] CNT
`ifdef DFFNS_PIPE_NOTIFIER_EN
  ,
  input  logic                       notifier
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_in;
  logic [DEPTH-1:0][WIDTH-1:0] data_in;
  logic [CW-1:0]               cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign vld_in[i]  = VLD_I;
      assign data_in[i] = D;
    end else begin : g_body
      assign vld_in[i]  = vld_q[i-1];
      assign data_in[i] = data_q[i-1];
    end

    dffns_pipe_stage #(
      .WIDTH     (WIDTH),
      .SET_VALUE (SET_VALUE)
    ) u_stage (
      .clkn_i  (CLKN),
      .set_i   (SET),
      .en_i    (EN),
      .flush_i (FLUSH),
      .vld_i   (vld_in[i]),
      .data_i  (data_in[i]),
      .vld_o   (vld_q[i]),
      .data_o  (data_q[i])
`ifdef DFFNS_PIPE_NOTIFIER_EN
      ,
      .notifier(notifier)
`endif
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(vld_q[i]);
  end

  assign Q     = data_q[DEPTH-1];
  assign VLD_O = vld_q[DEPTH-1];
  assign CNT   = cnt;

endmodule

// File: tb/tb_dffns_pipe.sv
// Directed bench for dffns_pipe: WIDTH=8, DEPTH=4, SET_VALUE=8'hFF.
module tb_dffns_pipe;

  logic       CLKN = 1'b1;
  logic       SET = 1'b0, EN = 1'b1, FLUSH = 1'b0, VLD_I = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] Q;
  logic       VLD_O;
  logic [2:0] CNT;
`ifdef DFFNS_PIPE_NOTIFIER_EN
  logic       notifier = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  dffns_pipe #(.WIDTH(8), .DEPTH(4), .SET_VALUE(8'hFF)) dut (
    .CLKN(CLKN), .SET(SET), .EN(EN), .FLUSH(FLUSH), .VLD_I(VLD_I), .D(D),
    .Q(Q), .VLD_O(VLD_O), .CNT(CNT)
`ifdef DFFNS_PIPE_NOTIFIER_EN
    , .notifier(notifier)
`endif
  );

  always #5 CLKN = ~CLKN;

  // Advance one falling edge and settle 1 ns past it.
  task automatic tick();
    @(negedge CLKN);
    #1;
  endtask

  task automatic test_reset();
    #1 SET = 1'b1;
    #1;
    nvec++; if (Q !== 8'hFF) begin nerr++; $display("FAIL reset_q: got %h exp ff", Q); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL reset_vld: got %b exp 0", VLD_O); end
    nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL reset_cnt: got %0d exp 0", CNT); end
    D = 8'h11; VLD_I = 1'b1; EN = 1'b1;
    @(negedge CLKN);
    #1 SET = 1'b0;
    VLD_I = 1'b0;
    nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL release_cnt: got %0d exp 0", CNT); end
    nvec++; if (Q !== 8'hFF) begin nerr++; $display("FAIL release_q: got %h exp ff", Q); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL release_vld: got %b exp 0", VLD_O); end
  endtask

  task automatic test_stream();
    logic [7:0] expq;
    for (int k = 1; k <= 4; k++) begin
      D = 8'(k); VLD_I = 1'b1;
      tick();
    end
    nvec++; if (Q !== 8'h01) begin nerr++; $display("FAIL stream_q1: got %h exp 01", Q); end
    nvec++; if (VLD_O !== 1'b1) begin nerr++; $display("FAIL stream_vld1: got %b exp 1", VLD_O); end
    nvec++; if (CNT !== 3'd4) begin nerr++; $display("FAIL stream_cnt_full: got %0d exp 4", CNT); end
    D = 8'h00; VLD_I = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      expq = (k <= 4) ? 8'(k) : 8'h04;
      nvec++; if (Q !== expq) begin nerr++; $display("FAIL stream_q%0d: got %h exp %h", k, Q, expq); end
      nvec++; if (VLD_O !== (k <= 4)) begin nerr++; $display("FAIL stream_vld%0d: got %b exp %b", k, VLD_O, (k <= 4)); end
      nvec++; if (CNT !== 3'(5 - k)) begin nerr++; $display("FAIL stream_cnt%0d: got %0d exp %0d", k, CNT, 5 - k); end
    end
  endtask

  task automatic test_bubbles_stall();
    D = 8'hA5; VLD_I = 1'b1;
    tick();
    D = 8'h00; VLD_I = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    nvec++; if (Q !== 8'hA5) begin nerr++; $display("FAIL bubble_q: got %h exp a5", Q); end
    nvec++; if (VLD_O !== 1'b1) begin nerr++; $display("FAIL bubble_vld: got %b exp 1", VLD_O); end
    nvec++; if (CNT !== 3'd1) begin nerr++; $display("FAIL bubble_cnt: got %0d exp 1", CNT); end
    EN = 1'b0; D = 8'h77; VLD_I = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      nvec++; if (Q !== 8'hA5) begin nerr++; $display("FAIL stall_q%0d: got %h exp a5", k, Q); end
      nvec++; if (VLD_O !== 1'b1) begin nerr++; $display("FAIL stall_vld%0d: got %b exp 1", k, VLD_O); end
      nvec++; if (CNT !== 3'd1) begin nerr++; $display("FAIL stall_cnt%0d: got %0d exp 1", k, CNT); end
    end
    EN = 1'b1; D = 8'h00; VLD_I = 1'b0;
    tick();
    nvec++; if (Q !== 8'hA5) begin nerr++; $display("FAIL bubble_keep_q: got %h exp a5", Q); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL bubble_drain_vld: got %b exp 0", VLD_O); end
    nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL bubble_drain_cnt: got %0d exp 0", CNT); end
  endtask

  task automatic test_flush();
    logic [7:0] w [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int k = 0; k < 4; k++) begin
      D = w[k]; VLD_I = 1'b1;
      tick();
    end
    nvec++; if (CNT !== 3'd4) begin nerr++; $display("FAIL flush_fill_cnt: got %0d exp 4", CNT); end
    FLUSH = 1'b1; EN = 1'b1; VLD_I = 1'b1; D = 8'h50;
    tick();
    FLUSH = 1'b0; VLD_I = 1'b0; D = 8'h00;
    nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL flush_cnt: got %0d exp 0", CNT); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL flush_vld: got %b exp 0", VLD_O); end
    nvec++; if (Q !== 8'h10) begin nerr++; $display("FAIL flush_q: got %h exp 10", Q); end
    tick();
    nvec++; if (Q !== 8'h10) begin nerr++; $display("FAIL flush_hold_q: got %h exp 10", Q); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL flush_hold_vld: got %b exp 0", VLD_O); end
  endtask

  task automatic test_set_midstream();
    for (int k = 1; k <= 3; k++) begin
      D = 8'h60 + 8'(k); VLD_I = 1'b1;
      tick();
    end
    VLD_I = 1'b0; D = 8'h00;
    nvec++; if (CNT !== 3'd3) begin nerr++; $display("FAIL mid_cnt_pre: got %0d exp 3", CNT); end
    #2 SET = 1'b1;
    #1;
    nvec++; if (Q !== 8'hFF) begin nerr++; $display("FAIL mid_set_q: got %h exp ff", Q); end
    nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL mid_set_cnt: got %0d exp 0", CNT); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL mid_set_vld: got %b exp 0", VLD_O); end
    SET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      nvec++; if (Q !== 8'hFF) begin nerr++; $display("FAIL mid_stale_q%0d: got %h exp ff", k, Q); end
      nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL mid_stale_vld%0d: got %b exp 0", k, VLD_O); end
      nvec++; if (CNT !== 3'd0) begin nerr++; $display("FAIL mid_stale_cnt%0d: got %0d exp 0", k, CNT); end
    end
  endtask

  // A stall in the middle of a stream adds exactly one edge of latency.
  task automatic test_back_to_back();
    D = 8'hC1; VLD_I = 1'b1; EN = 1'b1;
    tick();
    EN = 1'b0; D = 8'hEE;
    tick();
    EN = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      D = 8'hC0 + 8'(k);
      tick();
      if (k < 4) begin
        nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL b2b_early_vld%0d: got %b exp 0", k, VLD_O); end
      end
    end
    VLD_I = 1'b0;
    nvec++; if (Q !== 8'hC1) begin nerr++; $display("FAIL b2b_q: got %h exp c1", Q); end
    nvec++; if (VLD_O !== 1'b1) begin nerr++; $display("FAIL b2b_vld: got %b exp 1", VLD_O); end
    nvec++; if (CNT !== 3'd4) begin nerr++; $display("FAIL b2b_cnt: got %0d exp 4", CNT); end
    tick();
    nvec++; if (Q !== 8'hC2) begin nerr++; $display("FAIL b2b_q2: got %h exp c2", Q); end
  endtask

`ifdef DFFNS_PIPE_NOTIFIER_EN
  task automatic test_notifier();
    #2 notifier = ~notifier;
    #1;
    nvec++; if (Q !== 8'hxx) begin nerr++; $display("FAIL notif_q: got %h exp xx", Q); end
    nvec++; if (VLD_O !== 1'bx) begin nerr++; $display("FAIL notif_vld: got %b exp x", VLD_O); end
    SET = 1'b1;
    #1 SET = 1'b0;
    nvec++; if (Q !== 8'hFF) begin nerr++; $display("FAIL notif_set_q: got %h exp ff", Q); end
    nvec++; if (VLD_O !== 1'b0) begin nerr++; $display("FAIL notif_set_vld: got %b exp 0", VLD_O); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_bubbles_stall();
    test_flush();
    test_set_midstream();
    test_back_to_back();
`ifdef DFFNS_PIPE_NOTIFIER_EN
    test_notifier();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
